banco_autotest: RTL and testbench

//  Write/read master for the 8x4 register bank (BancoRegistro). On start it fills every

---
 rtl/banco_autotest_if.sv | 23 ++
 rtl/banco_autotest.sv | 138 +++++++++++++
 tb/tb_banco_autotest.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/banco_autotest_if.sv
// Bus between the self-test master and the 8x4 register bank: one write port, two combinational read ports.
interface banco_autotest_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] addrW;
    logic [DATA_W-1:0] datW;
    logic              RegWrite;
    logic [ADDR_W-1:0] addrRa;
    logic [ADDR_W-1:0] addrRb;
    logic [DATA_W-1:0] datOutRa;
    logic [DATA_W-1:0] datOutRb;

    modport master (
        output addrW, datW, RegWrite, addrRa, addrRb,
        input  datOutRa, datOutRb
    );

    modport slave (
        input  addrW, datW, RegWrite, addrRa, addrRb,
        output datOutRa, datOutRb
    );
endinterface

// File: rtl/banco_autotest.sv
// Power-on self-test master for the register bank: writes a seeded pattern,
// then reads it back on both ports (A ascending, B descending) and tallies mismatches.
module banco_autotest #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int NREG   = 8
) (
    input  logic                clk1,
    input  logic                rst1,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed,
    banco_autotest_if.master    bank,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ADDR_W+1:0]   err_cnt,
    output logic [2:0]          dbgState
);

    // Handshake: start is a level sampled only in IDLE; done is a one-cycle
    // pulse in DONE, after which err/err_addr/err_cnt hold until the next run.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RCMP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] seedQ;

    logic              mismA;
    logic              mismB;
    logic [1:0]        nMism;
    logic [ADDR_W-1:0] idxB;

    function automatic logic [DATA_W-1:0] patOf(input logic [ADDR_W-1:0] i,
                                                input logic [DATA_W-1:0] s);
        return DATA_W'(i) + s;
    endfunction

    always_comb begin
        idxB  = LAST - idx;
        mismA = (bank.datOutRa != patOf(idx, seedQ));
        mismB = (bank.datOutRb != patOf(idxB, seedQ));
        nMism = {1'b0, mismA} + {1'b0, mismB};
    end

    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge clk1) begin
        if (!rst1) begin
            state         <= IDLE;
            idx           <= '0;
            seedQ         <= '0;
            bank.addrW    <= '0;
            bank.datW     <= '0;
            bank.RegWrite <= 1'b0;
            bank.addrRa   <= '0;
            bank.addrRb   <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_addr      <= '0;
            err_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= WRITE;
                        idx           <= '0;
                        seedQ         <= seed;
                        err           <= 1'b0;
                        err_addr      <= '0;
                        err_cnt       <= '0;
                        bank.RegWrite <= 1'b1;
                        bank.addrW    <= '0;
                        bank.datW     <= seed;
                    end
                end
                WRITE: begin
                    if (idx == LAST) begin
                        state         <= RADDR;
                        idx           <= '0;
                        bank.RegWrite <= 1'b0;
                        bank.addrW    <= '0;
                        bank.datW     <= '0;
                        bank.addrRa   <= '0;
                        bank.addrRb   <= LAST;
                    end else begin
                        idx        <= idx + ONE;
                        bank.addrW <= idx + ONE;
                        bank.datW  <= patOf(idx + ONE, seedQ);
                    end
                end
                RADDR: begin
                    state <= RCMP;
                end
                RCMP: begin
                    err_cnt <= err_cnt + {{ADDR_W{1'b0}}, nMism};
                    if (mismA || mismB) begin
                        err <= 1'b1;
                        // Only the first failing address of a run is kept; A wins ties.
                        if (!err) err_addr <= mismA ? idx : idxB;
                    end
                    if (idx == LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        bank.addrRa <= '0;
                        bank.addrRb <= '0;
                    end else begin
                        state       <= RADDR;
                        idx         <= idx + ONE;
                        bank.addrRa <= idx + ONE;
                        bank.addrRb <= idxB - ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banco_autotest.sv
// Directed bench for banco_autotest with a behavioural 8x4 register bank and an optional stuck-at-0 register 3.
module tb_banco_autotest;

    logic       clk1;
    logic       rst1;
    logic       start;
    logic [3:0] seed;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] errAddr;
    logic [4:0] errCnt;
    logic [2:0] dbgState;

    banco_autotest_if #(.ADDR_W(3), .DATA_W(4)) bif ();

    banco_autotest #(.ADDR_W(3), .DATA_W(4), .NREG(8)) dut (
        .clk1     (clk1),
        .rst1     (rst1),
        .start    (start),
        .seed     (seed),
        .bank     (bif.master),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (errAddr),
        .err_cnt  (errCnt),
        .dbgState (dbgState)
    );

    // Clock
    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Bank model
    logic [3:0] bankMem [8];
    logic       stuckEn;

    initial begin
        for (int i = 0; i < 8; i++) bankMem[i] = 4'hA;
    end

    always @(posedge clk1) begin
        if (bif.RegWrite) bankMem[bif.addrW] <= bif.datW;
    end

    assign bif.datOutRa = (stuckEn && bif.addrRa == 3'd3) ? 4'h0 : bankMem[bif.addrRa];
    assign bif.datOutRb = (stuckEn && bif.addrRb == 3'd3) ? 4'h0 : bankMem[bif.addrRb];

    // Scoreboard
    int         nChecks;
    int         nFails;
    logic [3:0] expQ[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
        nChecks++;
        if (got !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Driver: one full run; expQ must hold the eight expected write data values.
    task automatic runTest(input string tag, input logic [3:0] seedIn, input bit pulseMid,
                           input bit holdStart, input logic expErr, input logic [2:0] expAddr,
                           input logic [4:0] expCnt);
        int cyc;
        int doneCyc;
        logic [3:0] expD;
        seed  = seedIn;
        start = 1'b1;
        tick();
        if (!holdStart) start = 1'b0;
        seed = ~seedIn;
        cyc  = 1;
        for (int k = 0; k < 8; k++) begin
            checkVal({tag, ".wen"}, bif.RegWrite, 1);
            checkVal({tag, ".addrW"}, bif.addrW, k);
            expD = (expQ.size() > 0) ? expQ.pop_front() : 4'h0;
            checkVal({tag, ".datW"}, bif.datW, expD);
            tick();
            cyc++;
        end
        checkVal({tag, ".rdWen"}, bif.RegWrite, 0);
        checkVal({tag, ".addrRa0"}, bif.addrRa, 0);
        checkVal({tag, ".addrRb0"}, bif.addrRb, 7);
        doneCyc = 0;
        while (cyc <= 40 && doneCyc == 0) begin
            if (done) begin
                doneCyc = cyc;
            end else begin
                if (!holdStart) start = (pulseMid && cyc == 12);
                tick();
                cyc++;
            end
        end
        start = holdStart;
        checkVal({tag, ".doneCyc"}, doneCyc, 25);
        checkVal({tag, ".busyDone"}, busy, 1);
        checkVal({tag, ".err"}, err, expErr);
        checkVal({tag, ".errAddr"}, errAddr, expAddr);
        checkVal({tag, ".errCnt"}, errCnt, expCnt);
        tick();
        checkVal({tag, ".donePulse"}, done, 0);
        checkVal({tag, ".idle"}, busy, 0);
        checkVal({tag, ".errHold"}, err, expErr);
        checkVal({tag, ".cntHold"}, errCnt, expCnt);
    endtask

    initial begin
        int doneSeen;
        int cyc;
        int doneCyc;
        nChecks = 0;
        nFails  = 0;
        stuckEn = 1'b0;
        rst1    = 1'b0;
        start   = 1'b1;
        seed    = 4'h9;

        // 1: reset with start held
        for (int i = 0; i < 3; i++) tick();
        checkVal("rst.busy", busy, 0);
        checkVal("rst.done", done, 0);
        checkVal("rst.err", err, 0);
        checkVal("rst.wen", bif.RegWrite, 0);
        checkVal("rst.addrW", bif.addrW, 0);
        checkVal("rst.datW", bif.datW, 0);
        checkVal("rst.addrRa", bif.addrRa, 0);
        checkVal("rst.addrRb", bif.addrRb, 0);
        checkVal("rst.errAddr", errAddr, 0);
        checkVal("rst.errCnt", errCnt, 0);
        checkVal("rst.state", dbgState, 0);
        start = 1'b0;
        rst1  = 1'b1;
        tick();
        checkVal("rst.stayIdle", busy, 0);

        // 2: good bank, seed 0, with a start pulse mid-run
        expQ = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        runTest("seed0", 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0);

        // 3: pattern wraps
        expQ = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        runTest("seedF", 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);

        // 4: register 3 stuck at 0
        stuckEn = 1'b1;
        expQ = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        runTest("stuck3", 4'h5, 1'b0, 1'b0, 1'b1, 3'd3, 5'd2);

        // 5: start held high; second run follows and clears err
        expQ = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        runTest("hold", 4'h5, 1'b0, 1'b1, 1'b1, 3'd3, 5'd2);
        stuckEn = 1'b0;
        tick();
        checkVal("hold.rerunBusy", busy, 1);
        checkVal("hold.rerunWen", bif.RegWrite, 1);
        checkVal("hold.rerunErr", err, 0);
        checkVal("hold.rerunCnt", errCnt, 0);
        checkVal("hold.rerunAddrW", bif.addrW, 0);
        start   = 1'b0;
        cyc     = 27;
        doneCyc = 0;
        while (cyc <= 70 && doneCyc == 0) begin
            if (done) doneCyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        checkVal("hold.rerunDoneCyc", doneCyc, 51);
        checkVal("hold.rerunErrEnd", err, 0);

        // 6: reset in the middle of WRITE
        tick();
        seed  = 4'h2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkVal("midRst.addrW", bif.addrW, 4);
        checkVal("midRst.datW", bif.datW, 6);
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        checkVal("midRst.wen", bif.RegWrite, 0);
        checkVal("midRst.busy", busy, 0);
        checkVal("midRst.addrW0", bif.addrW, 0);
        checkVal("midRst.state", dbgState, 0);
        doneSeen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) doneSeen++;
            tick();
        end
        checkVal("midRst.noDone", doneSeen, 0);
        checkVal("midRst.stillIdle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
